// File: rtl/vc_buffer_pkg.sv
// Shared constants and payload types for the virtual-channel input buffer.
// Optional error outputs are enabled with the VC_INPUT_BUFFER_ERR_EN macro.
package vc_buffer_pkg;

    localparam int unsigned NUM_VC_DEF      = 2;
    localparam int unsigned ADDR_WIDTH_DEF  = 2;
    localparam int unsigned DATA_WIDTH_DEF  = 64;
    // Credit register holds VC ids up to this width; narrower ids are zero-extended.
    localparam int unsigned VC_ID_MAX_WIDTH = 8;

    typedef logic [DATA_WIDTH_DEF-1:0] flit_t;

    typedef struct packed {
        logic                       valid;
        logic [VC_ID_MAX_WIDTH-1:0] vc;
    } credit_t;

endpackage

// File: rtl/vc_input_buffer_ptr_ctrl.sv
// Per-VC pointer pair: occupancy status, accept decisions and sticky error flags.
// Error flags exist only when VC_INPUT_BUFFER_ERR_EN is defined.
module vc_ptr_ctrl
    import vc_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    output logic                  push_ok,
    output logic                  pop_ok,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr
`ifdef VC_INPUT_BUFFER_ERR_EN
    ,
    output logic                  overflow_err,
    output logic                  underflow_err
`endif
);

    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                     (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign count   = wptr - rptr;
    assign wr_addr = wptr[ADDR_WIDTH-1:0];
    assign rd_addr = rptr[ADDR_WIDTH-1:0];

    // A pop on a full VC frees the slot the simultaneous push lands in.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_WIDTH'(1);
            if (pop_ok)  rptr <= rptr + PTR_WIDTH'(1);
        end
    end

`ifdef VC_INPUT_BUFFER_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (push && !push_ok) overflow_err  <= 1'b1;
            if (pop && !pop_ok)   underflow_err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/vc_input_buffer.sv
// Router input buffer: NUM_VC first-word-fall-through FIFOs sharing one push and one pop port.
// Define VC_INPUT_BUFFER_ERR_EN to add sticky overflow_err/underflow_err outputs.
module vc_input_buffer
    import vc_buffer_pkg::*;
#(
    parameter  int unsigned NUM_VC     = NUM_VC_DEF,
    parameter  int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH,
    localparam int unsigned VC_WIDTH   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  logic [VC_WIDTH-1:0]                 push_vc,
    input  logic [DATA_WIDTH-1:0]               din,
    input  logic                                pop,
    input  logic [VC_WIDTH-1:0]                 pop_vc,
    output logic [NUM_VC-1:0][DATA_WIDTH-1:0]   dout,
    output logic [NUM_VC-1:0]                   empty,
    output logic [NUM_VC-1:0]                   full,
    output logic [NUM_VC-1:0][ADDR_WIDTH:0]     count,
    output logic                                credit_valid,
    output logic [VC_WIDTH-1:0]                 credit_vc
`ifdef VC_INPUT_BUFFER_ERR_EN
    ,
    output logic [NUM_VC-1:0]                   overflow_err,
    output logic [NUM_VC-1:0]                   underflow_err
`endif
);

    logic [NUM_VC-1:0]                 push_ok;
    logic [NUM_VC-1:0]                 pop_ok;
    logic [NUM_VC-1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_VC-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]             mem [NUM_VC][DEPTH];
    credit_t                           credit_q;

    // Out-of-range VC ids match no instance, so they are dropped/ignored naturally.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_ptr_ctrl #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ptr (
            .clk           (clk),
            .reset         (reset),
            .push          (push && (push_vc == VC_WIDTH'(v))),
            .pop           (pop && (pop_vc == VC_WIDTH'(v))),
            .push_ok       (push_ok[v]),
            .pop_ok        (pop_ok[v]),
            .empty         (empty[v]),
            .full          (full[v]),
            .count         (count[v]),
            .wr_addr       (wr_addr[v]),
            .rd_addr       (rd_addr[v])
`ifdef VC_INPUT_BUFFER_ERR_EN
            ,
            .overflow_err  (overflow_err[v]),
            .underflow_err (underflow_err[v])
`endif
        );

        assign dout[v] = mem[v][rd_addr[v]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[v][i] <= '0;
                end
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_ok[v]) mem[v][wr_addr[v]] <= din;
            end
        end
    end

    // One credit per accepted pop; the VC id holds between credits.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= '0;
        end else begin
            credit_q.valid <= |pop_ok;
            if (|pop_ok) credit_q.vc <= VC_ID_MAX_WIDTH'(pop_vc);
        end
    end

    assign credit_valid = credit_q.valid;
    assign credit_vc    = VC_WIDTH'(credit_q.vc);

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer: vector table plus per-VC queue scoreboard.
// Checks the sticky error outputs when VC_INPUT_BUFFER_ERR_EN is defined.
module tb_vc_input_buffer;
    import vc_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic [0:0]       push_vc;
    flit_t            din;
    logic             pop;
    logic [0:0]       pop_vc;
    logic [1:0][63:0] dout;
    logic [1:0]       empty;
    logic [1:0]       full;
    logic [1:0][2:0]  count;
    logic             credit_valid;
    logic [0:0]       credit_vc;
`ifdef VC_INPUT_BUFFER_ERR_EN
    logic [1:0]       overflow_err;
    logic [1:0]       underflow_err;
`endif

    vc_input_buffer #(
        .NUM_VC     (2),
        .ADDR_WIDTH (2),
        .DATA_WIDTH (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .push_vc       (push_vc),
        .din           (din),
        .pop           (pop),
        .pop_vc        (pop_vc),
        .dout          (dout),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .credit_valid  (credit_valid),
        .credit_vc     (credit_vc)
`ifdef VC_INPUT_BUFFER_ERR_EN
        ,
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic        pv;
        logic [63:0] d;
        logic        q;
        logic        qv;
        int          e0;
        int          e1;
        logic        ecv;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mq [2][$];
    logic        cred_q [$];
    logic [1:0]  m_ovf;
    logic [1:0]  m_unf;
    vec_t        tab [21];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic p, input logic pv, input logic [63:0] d,
                                input logic q, input logic qv,
                                input int e0, input int e1, input logic ecv);
        vec_t r;
        r.p = p; r.pv = pv; r.d = d; r.q = q; r.qv = qv;
        r.e0 = e0; r.e1 = e1; r.ecv = ecv;
        return r;
    endfunction

    task automatic check_outputs(input bit use_tab, input int e0, input int e1, input logic ecv);
        logic exp_cv;
        logic exp_vc;
        exp_cv = (cred_q.size() > 0);
        chk("credit_valid", 64'(credit_valid), 64'(exp_cv));
        if (exp_cv) begin
            exp_vc = cred_q.pop_front();
            chk("credit_vc", 64'(credit_vc), 64'(exp_vc));
        end
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("count%0d", v), 64'(count[v]), 64'(mq[v].size()));
            chk($sformatf("empty%0d", v), 64'(empty[v]), 64'(mq[v].size() == 0));
            chk($sformatf("full%0d", v), 64'(full[v]), 64'(mq[v].size() == DEPTH));
            if (mq[v].size() > 0) chk($sformatf("head%0d", v), dout[v], mq[v][0]);
        end
        if (use_tab) begin
            chk("tab_count0", 64'(count[0]), 64'(e0));
            chk("tab_count1", 64'(count[1]), 64'(e1));
            chk("tab_credit", 64'(credit_valid), 64'(ecv));
        end
`ifdef VC_INPUT_BUFFER_ERR_EN
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("underflow_err", 64'(underflow_err), 64'(m_unf));
`endif
    endtask

    task automatic step(input logic p, input logic pv, input logic [63:0] d,
                        input logic q, input logic qv,
                        input bit use_tab, input int e0, input int e1, input logic ecv);
        bit pa;
        bit qa;
        push = p; push_vc = pv; din = d; pop = q; pop_vc = qv;
        qa = q && (mq[qv].size() > 0);
        pa = p && ((mq[pv].size() < DEPTH) || (qa && (qv == pv)));
        if (qa) begin
            chk("pop_data", dout[qv], mq[qv][0]);
            cred_q.push_back(qv);
        end
        if (p && !pa) m_ovf[pv] = 1'b1;
        if (q && !qa) m_unf[qv] = 1'b1;
        @(posedge clk);
        #1;
        if (qa) void'(mq[qv].pop_front());
        if (pa) mq[pv].push_back(d);
        push = 1'b0;
        pop  = 1'b0;
        check_outputs(use_tab, e0, e1, ecv);
    endtask

    // Reset may be applied with a push and pop in flight; both must be discarded.
    task automatic do_reset(input bit with_traffic);
        reset = 1'b1;
        push = with_traffic; push_vc = 1'b0; din = 64'hFF;
        pop  = with_traffic; pop_vc  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        mq[0].delete();
        mq[1].delete();
        cred_q.delete();
        m_ovf = '0;
        m_unf = '0;
        chk("rst_empty", 64'(empty), 64'h3);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_credit", 64'(credit_valid), 64'h0);
        chk("rst_credit_vc", 64'(credit_vc), 64'h0);
        chk("rst_dout0", dout[0], 64'h0);
        chk("rst_dout1", dout[1], 64'h0);
        check_outputs(1'b1, 0, 0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; push_vc = '0; din = '0; pop = 1'b0; pop_vc = '0;
        m_ovf = '0; m_unf = '0;

        tab[0]  = mk(1, 1, 64'hA0, 0, 0, 0, 1, 0);
        tab[1]  = mk(1, 1, 64'hA1, 0, 0, 0, 2, 0);
        tab[2]  = mk(1, 1, 64'hA2, 0, 0, 0, 3, 0);
        tab[3]  = mk(1, 1, 64'hA3, 0, 0, 0, 4, 0);
        tab[4]  = mk(1, 1, 64'hA4, 0, 0, 0, 4, 0);
        tab[5]  = mk(0, 0, 64'h0,  1, 1, 0, 3, 1);
        tab[6]  = mk(0, 0, 64'h0,  1, 1, 0, 2, 1);
        tab[7]  = mk(0, 0, 64'h0,  1, 1, 0, 1, 1);
        tab[8]  = mk(0, 0, 64'h0,  1, 1, 0, 0, 1);
        tab[9]  = mk(0, 0, 64'h0,  1, 1, 0, 0, 0);
        tab[10] = mk(1, 0, 64'h10, 0, 0, 1, 0, 0);
        tab[11] = mk(1, 0, 64'h11, 0, 0, 2, 0, 0);
        tab[12] = mk(1, 0, 64'h12, 0, 0, 3, 0, 0);
        tab[13] = mk(1, 0, 64'h13, 0, 0, 4, 0, 0);
        tab[14] = mk(1, 0, 64'hB0, 1, 0, 4, 0, 1);
        tab[15] = mk(0, 0, 64'h0,  1, 0, 3, 0, 1);
        tab[16] = mk(0, 0, 64'h0,  1, 0, 2, 0, 1);
        tab[17] = mk(0, 0, 64'h0,  1, 0, 1, 0, 1);
        tab[18] = mk(0, 0, 64'h0,  1, 0, 0, 0, 1);
        tab[19] = mk(1, 0, 64'hC0, 1, 0, 1, 0, 0);
        tab[20] = mk(0, 0, 64'h0,  1, 0, 0, 0, 1);

        @(posedge clk);
        #1;
        do_reset(1'b0);

        for (int i = 0; i < 21; i++) begin
            step(tab[i].p, tab[i].pv, tab[i].d, tab[i].q, tab[i].qv,
                 1'b1, tab[i].e0, tab[i].e1, tab[i].ecv);
        end

        // Interleaved traffic drives each VC's pointers through a full wrap.
        for (int i = 0; i < 18; i++) begin
            step(1'b1, logic'(i[0]), 64'hD0 + 64'(i), i >= 2, logic'(~i[0]),
                 1'b0, 0, 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b1, logic'(i[0]), 1'b0, 0, 0, 1'b0);
        end

        do_reset(1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 64'hE0 + 64'(i), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        end
        step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 3, 0, 1'b1);
        do_reset(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
